sram_bist_target: RTL and testbench
===================================

Name: sram_bist_target

Overview:
- Behavioural SRAM responder on the memory side of the MBIST interface; the March controllers drive it.
- Accepts address, write data and write enable from the controller.
- Returns read data after a fixed, parameterised pipeline latency.
- Supports single-cell fault injection (stuck-at-0, stuck-at-1, up-transition) so benches can prove the March algorithms detect faults.
- Sweeps the array to INIT_VAL after reset before accepting traffic.

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 4, word width.
- READ_LAT, 3, read pipeline depth in clock edges; legal range 1..8.
- INIT_VAL, 0, word value written to every address during post-reset sweep.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- addr_in  in  ADDR_W  address from BIST controller.
- dat_in  in  DATA_W  write data from BIST controller.
- w_en_in  in  1  write enable from BIST controller.
- dat_out  out  DATA_W  read data to BIST controller.
- ready  out  1  high once init sweep completes.
- flt_load  in  1  strobe: capture fault config this edge.
- flt_type  in  2  00 none, 01 SA0, 10 SA1, 11 up-transition fault (TF-up).
- flt_addr  in  ADDR_W  faulty cell address.
- flt_bit  in  $clog2(DATA_W)  faulty bit index.
- wr_cnt  out  16  accepted writes since ready; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at edge):
  - dat_out=0, ready=0, wr_cnt=0; fault config cleared to type 00.
  - Read pipeline flushed to 0; init counter=0; FSM enters INIT.
  - Reset asserted mid-sweep or mid-traffic restarts INIT from address 0; array contents not otherwise guaranteed until sweep ends.
- FSM INIT:
  - Each edge writes INIT_VAL to mem[init_cnt] and increments init_cnt.
  - After the write to DEPTH-1, go to READY; ready=1 after that edge. INIT lasts exactly DEPTH edges after reset release.
  - In INIT, w_en_in is ignored, dat_out holds 0 and pipeline inputs are forced to 0.
  - Fault injection does not apply to init writes.
- FSM READY: terminal state until rst.
- Write (READY, w_en_in=1 at edge):
  - Stored word = dat_in, modified at flt_addr/flt_bit by the active fault.
  - SA0: bit forced 0. SA1: bit forced 1. TF-up: if stored bit is 0 and new bit is 1, bit stays 0; 1->0 is allowed.
  - Increment wr_cnt unless it equals FFFF.
- Read:
  - Array is read every READY edge regardless of w_en_in.
  - The word at the addr_in presented before edge n appears on dat_out immediately after edge n+READ_LAT-1.
  - With the default of 3: controller drives the address after edge 0, memory samples it at edge 1, dat_out is valid after edge 3, and the controller samples at edge 4.
  - Same-edge read and write to one address: read returns old data (read-before-write); new data is visible on the next read sample.
  - SA0/SA1 are also applied to the read value of the faulty cell, so cells are stuck even if the fault was loaded after the cell was written. TF-up affects writes only.
- Fault load:
  - flt_load=1 at edge captures flt_type/flt_addr/flt_bit; applies from the next edge.
  - Allowed in INIT or READY; rst overrides flt_load.
- Address wrap: N/A; every addr_in value is a valid word.
- dat_out changes only at clock edges; no combinational path from inputs.

Test Plan:
- Reset, then release rst; count edges -> ready rises exactly 256 edges after release; any read returns 4'h0.
- Write 4'hA to addr 8'h05, address 8'h05 with w_en_in=0 after edge k -> dat_out=4'hA after edge k+3 and not before (old value 4'h0 at k+2).
- Load SA1, addr 8'h10, bit 2; write 4'h0 to 8'h10; read -> 4'h4. Load SA0 bit 2 on a cell previously written 4'hF -> reads 4'hB.
- Load TF-up, addr 8'hFF, bit 0; write 4'h0, then 4'hF, then read -> 4'hE; write 4'h0 again, read -> 4'h0.
- Same-edge write 4'h3 and read at 8'h20 holding 4'hC -> pipeline returns 4'hC; following read returns 4'h3; wr_cnt increments by 1 per accepted write, 0 during INIT.
- Assert rst for one edge midway through a write sequence -> ready=0, dat_out=0, wr_cnt=0, fault cleared; array re-swept; all 256 addresses read INIT_VAL afterwards.

Source files
------------

// File: rtl/sram_bist_target.sv
// Behavioural SRAM responder for MBIST March controllers.
// Sweeps the array to INIT_VAL after reset, then serves one read every edge
// through a READ_LAT-deep pipeline and accepts writes when w_en_in is high.
// A single configurable cell fault (SA0, SA1, TF-up) can be injected.
module sram_bist_target #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 4,
    parameter int READ_LAT = 3,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] dat_in,
    input  logic              w_en_in,
    output logic [DATA_W-1:0] dat_out,
    output logic              ready,
    input  logic              flt_load,
    input  logic [1:0]        flt_type,
    input  logic [ADDR_W-1:0] flt_addr,
    input  logic [BIT_W-1:0]  flt_bit,
    output logic [15:0]       wr_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_SA0  = 2'b01;
    localparam logic [1:0] FLT_SA1  = 2'b10;
    localparam logic [1:0] FLT_TFU  = 2'b11;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;
    logic [1:0]          flt_type_q, flt_type_d;
    logic [ADDR_W-1:0]   flt_addr_q, flt_addr_d;
    logic [BIT_W-1:0]    flt_bit_q, flt_bit_d;
    logic [DATA_W-1:0]   rd_pipe_q [READ_LAT];
    logic [DATA_W-1:0]   rd_pipe_d [READ_LAT];

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                flt_hit;
    logic [DATA_W-1:0]   rd_word;

    // Stuck-at faults force the faulty bit whenever the cell is observed.
    function automatic logic [DATA_W-1:0] apply_stuck(
        input logic [DATA_W-1:0] word,
        input logic              hit,
        input logic [1:0]        ftype,
        input logic [BIT_W-1:0]  fbit
    );
        logic [DATA_W-1:0] r;
        r = word;
        if (hit && ftype == FLT_SA0) r[fbit] = 1'b0;
        if (hit && ftype == FLT_SA1) r[fbit] = 1'b1;
        return r;
    endfunction

    // Word actually stored on a write: stuck-at forcing plus a blocked 0->1 for TF-up.
    function automatic logic [DATA_W-1:0] apply_write(
        input logic [DATA_W-1:0] new_word,
        input logic [DATA_W-1:0] old_word,
        input logic              hit,
        input logic [1:0]        ftype,
        input logic [BIT_W-1:0]  fbit
    );
        logic [DATA_W-1:0] r;
        r = apply_stuck(new_word, hit, ftype, fbit);
        if (hit && ftype == FLT_TFU && !old_word[fbit] && new_word[fbit]) r[fbit] = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    assign flt_hit = (addr_in == flt_addr_q);
    assign rd_word = apply_stuck(mem_q[addr_in], flt_hit, flt_type_q, flt_bit_q);

    // Next-state: init sweep, write port selection, fault capture, read pipeline shift.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        flt_type_d = flt_type_q;
        flt_addr_d = flt_addr_q;
        flt_bit_d  = flt_bit_q;
        mem_we     = 1'b0;
        mem_waddr  = init_cnt_q;
        mem_wdata  = INIT_VAL;
        rd_pipe_d[0] = '0;
        for (int i = 1; i < READ_LAT; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        if (flt_load) begin
            flt_type_d = flt_type;
            flt_addr_d = flt_addr;
            flt_bit_d  = flt_bit;
        end

        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == {ADDR_W{1'b1}}) state_d = ST_READY;
            end
            ST_READY: begin
                rd_pipe_d[0] = rd_word;
                if (w_en_in) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_in;
                    mem_wdata = apply_write(dat_in, mem_q[addr_in], flt_hit,
                                            flt_type_q, flt_bit_q);
                    wr_cnt_d  = sat_inc(wr_cnt_q);
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Control and read-pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            wr_cnt_q   <= '0;
            flt_type_q <= FLT_NONE;
            flt_addr_q <= '0;
            flt_bit_q  <= '0;
            for (int i = 0; i < READ_LAT; i++) rd_pipe_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            flt_type_q <= flt_type_d;
            flt_addr_q <= flt_addr_d;
            flt_bit_q  <= flt_bit_d;
            for (int i = 0; i < READ_LAT; i++) rd_pipe_q[i] <= rd_pipe_d[i];
        end
    end

    // Storage array; read-before-write falls out of the registered write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
    end

    assign dat_out = rd_pipe_q[READ_LAT-1];
    assign ready   = (state_q == ST_READY);
    assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_sram_bist_target.sv
// Scoreboard bench for sram_bist_target: every driven edge pushes the word
// expected on dat_out READ_LAT-1 edges later; a negedge monitor pops it.
module tb_sram_bist_target;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 4;
    localparam int READ_LAT = 3;
    localparam int DEPTH    = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] dat_in;
    logic              w_en_in;
    logic [DATA_W-1:0] dat_out;
    logic              ready;
    logic              flt_load;
    logic [1:0]        flt_type;
    logic [ADDR_W-1:0] flt_addr;
    logic [1:0]        flt_bit;
    logic [15:0]       wr_cnt;

    always #5 clk = ~clk;

    sram_bist_target #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .READ_LAT(READ_LAT),
        .INIT_VAL(4'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr_in (addr_in),
        .dat_in  (dat_in),
        .w_en_in (w_en_in),
        .dat_out (dat_out),
        .ready   (ready),
        .flt_load(flt_load),
        .flt_type(flt_type),
        .flt_addr(flt_addr),
        .flt_bit (flt_bit),
        .wr_cnt  (wr_cnt)
    );

    typedef struct {
        int          due;
        logic [3:0]  val;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [3:0]  m_mem [DEPTH];
    int          m_init_left = DEPTH;
    logic [15:0] m_wr_cnt = '0;
    logic [1:0]  m_ft = '0;
    logic [7:0]  m_fa = '0;
    logic [1:0]  m_fb = '0;
    int          edge_n = 0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // One clock edge of stimulus; the model is advanced right after the edge.
    task automatic step(input logic r, input logic [7:0] a, input logic [3:0] d,
                        input logic we, input logic fl, input logic [1:0] ft,
                        input logic [7:0] fa, input logic [1:0] fb,
                        input logic use_k, input logic [3:0] k);
        logic [3:0] rv;
        logic [3:0] nv;
        exp_t e;
        rst = r; addr_in = a; dat_in = d; w_en_in = we;
        flt_load = fl; flt_type = ft; flt_addr = fa; flt_bit = fb;
        @(posedge clk);
        edge_n++;
        if (r) begin
            sb_q.delete();
            m_init_left = DEPTH;
            m_wr_cnt = '0;
            m_ft = '0; m_fa = '0; m_fb = '0;
            for (int i = 0; i < READ_LAT; i++) begin
                e.due = edge_n + i; e.val = 4'h0;
                sb_q.push_back(e);
            end
            mon_en = 1'b1;
        end else begin
            if (m_init_left > 0) begin
                m_mem[DEPTH - m_init_left] = 4'h0;
                m_init_left--;
                rv = 4'h0;
            end else begin
                rv = m_mem[a];
                if (a == m_fa && m_ft == 2'b01) rv[m_fb] = 1'b0;
                if (a == m_fa && m_ft == 2'b10) rv[m_fb] = 1'b1;
                if (we) begin
                    nv = d;
                    if (a == m_fa) begin
                        case (m_ft)
                            2'b01: nv[m_fb] = 1'b0;
                            2'b10: nv[m_fb] = 1'b1;
                            2'b11: if (!m_mem[a][m_fb] && d[m_fb]) nv[m_fb] = 1'b0;
                            default: ;
                        endcase
                    end
                    m_mem[a] = nv;
                    if (m_wr_cnt != 16'hFFFF) m_wr_cnt++;
                end
            end
            e.due = edge_n + READ_LAT - 1;
            e.val = use_k ? k : rv;
            sb_q.push_back(e);
            if (fl) begin
                m_ft = ft; m_fa = fa; m_fb = fb;
            end
        end
        #1;
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, a, 4'h0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00, 1'b0, 4'h0);
    endtask

    task automatic rdk(input logic [7:0] a, input logic [3:0] k);
        step(1'b0, a, 4'h0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00, 1'b1, k);
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] d);
        step(1'b0, a, d, 1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 1'b0, 4'h0);
    endtask

    task automatic wrk(input logic [7:0] a, input logic [3:0] d, input logic [3:0] k);
        step(1'b0, a, d, 1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 1'b1, k);
    endtask

    task automatic fload(input logic [1:0] ft, input logic [7:0] fa, input logic [1:0] fb);
        step(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, ft, fa, fb, 1'b0, 4'h0);
    endtask

    // Compare status outputs every cycle and the read data when an entry falls due.
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("ready", ready, (m_init_left == 0));
            check_eq("wr_cnt", wr_cnt, m_wr_cnt);
            if (sb_q.size() > 0 && sb_q[0].due == edge_n) begin
                mon_e = sb_q.pop_front();
                check_eq("dat_out", dat_out, mon_e.val);
            end
        end
    end

    initial begin
        step(1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 2'b00, 8'h00, 2'b00, 1'b0, 4'h0);
        step(1'b1, 8'h55, 4'h9, 1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 1'b0, 4'h0);

        // Init sweep: writes presented here must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'($urandom), 4'($urandom), 1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 1'b0, 4'h0);
        end
        rdk(8'h00, 4'h0);
        rdk(8'h77, 4'h0);
        rdk(8'hFF, 4'h0);

        // Basic write, read-before-write on the write edge, then new data.
        wrk(8'h05, 4'hA, 4'h0);
        rdk(8'h05, 4'hA);

        // Stuck-at-1 on a written cell, stuck-at-0 loaded after the write.
        fload(2'b10, 8'h10, 2'd2);
        wr(8'h10, 4'h0);
        rdk(8'h10, 4'h4);
        wr(8'h30, 4'hF);
        fload(2'b01, 8'h30, 2'd2);
        rdk(8'h30, 4'hB);

        // Up-transition fault: 0->1 blocked, 1->0 allowed.
        fload(2'b11, 8'hFF, 2'd0);
        wr(8'hFF, 4'h0);
        wr(8'hFF, 4'hF);
        rdk(8'hFF, 4'hE);
        wr(8'hFF, 4'h0);
        rdk(8'hFF, 4'h0);

        // Same-edge read and write returns old data.
        fload(2'b00, 8'h00, 2'd0);
        wr(8'h20, 4'hC);
        wrk(8'h20, 4'h3, 4'hC);
        rdk(8'h20, 4'h3);

        // Random traffic with occasional fault loads and a one-edge reset midway.
        for (int i = 0; i < 150; i++) begin
            if (i == 75) begin
                step(1'b1, 8'($urandom_range(0, 15)), 4'($urandom), 1'b1, 1'b1,
                     2'b10, 8'h03, 2'd1, 1'b0, 4'h0);
            end else begin
                step(1'b0, 8'($urandom_range(0, 15)), 4'($urandom), 1'($urandom),
                     ($urandom_range(0, 19) == 0), 2'($urandom), 8'($urandom_range(0, 15)),
                     2'($urandom), 1'b0, 4'h0);
            end
        end
        while (m_init_left > 0) rd(8'($urandom));

        // After the re-sweep every cell holds INIT_VAL and no fault remains.
        for (int a = 0; a < DEPTH; a++) rdk(8'(a), 4'h0);

        repeat (READ_LAT) begin
            @(posedge clk);
            edge_n++;
            #1;
        end
        @(negedge clk);
        #1;
        check_eq("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
